// File: rtl/binary_clock_pkg.sv
// Shared widths, limits, set-mode encoding and wrap helpers for the binary clock set controller.
package binary_clock_pkg;

  localparam int HOURS_W  = 5;
  localparam int MINSEC_W = 6;

  localparam logic [HOURS_W-1:0]  HOURS_MAX  = 5'd23;
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    SET_HOURS   = 2'd1,
    SET_MINUTES = 2'd2,
    SET_SECONDS = 2'd3
  } set_state_t;

  function automatic logic [HOURS_W-1:0] hours_step(input logic [HOURS_W-1:0] value,
                                                    input logic up);
    if (up) return (value >= HOURS_MAX) ? '0 : value + HOURS_W'(1);
    return (value == '0 || value > HOURS_MAX) ? HOURS_MAX : value - HOURS_W'(1);
  endfunction

  function automatic logic [MINSEC_W-1:0] minsec_step(input logic [MINSEC_W-1:0] value,
                                                      input logic up);
    if (up) return (value >= MINSEC_MAX) ? '0 : value + MINSEC_W'(1);
    return (value == '0 || value > MINSEC_MAX) ? MINSEC_MAX : value - MINSEC_W'(1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus counting debouncer; emits a one-cycle pulse on each accepted press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Any sample that agrees with the stable level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg   <= '0;
        level_reg <= sync_reg[1];
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/binary_clock_set_ctrl.sv
// Set-mode controller: edits shadow time fields and commits them with a single load pulse.
// Define BINARY_CLOCK_AUTO_REPEAT_EN to auto-repeat inc/dec while the button is held.
module binary_clock_set_ctrl
  import binary_clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_mode,
  input  logic                btn_inc,
  input  logic                btn_dec,
  input  logic [HOURS_W-1:0]  cur_hours,
  input  logic [MINSEC_W-1:0] cur_minutes,
  input  logic [MINSEC_W-1:0] cur_seconds,
  output logic                tick_en,
  output logic                load,
  output logic [HOURS_W-1:0]  edit_hours,
  output logic [MINSEC_W-1:0] edit_minutes,
  output logic [MINSEC_W-1:0] edit_seconds,
  output logic [1:0]          set_mode,
  output logic                blink
);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

  logic [2:0] raw_vec;
  logic [2:0] level_vec;
  logic [2:0] press_vec;
  logic       mode_press, inc_press, dec_press;
  logic       inc_step, dec_step;
  logic       unused_levels;

  set_state_t           state_reg;
  logic                 load_reg;
  logic [HOURS_W-1:0]   edit_hours_reg;
  logic [MINSEC_W-1:0]  edit_minutes_reg;
  logic [MINSEC_W-1:0]  edit_seconds_reg;
  logic [BLINK_W-1:0]   blink_cnt_reg;
  logic                 blink_reg;

  assign raw_vec = {btn_dec, btn_inc, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  assign mode_press    = press_vec[0];
  assign inc_press     = press_vec[1];
  assign dec_press     = press_vec[2];
  assign unused_levels = ^level_vec;

`ifdef BINARY_CLOCK_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             rpt_armed_reg;
  logic             rpt_active;
  logic             rpt_fire;

  // Repeat only runs for a press accepted in a SET state and ends on release or mode.
  assign rpt_active = rpt_armed_reg && (level_vec[1] ^ level_vec[2]) && (state_reg != RUN);
  assign rpt_fire   = rpt_active && (rpt_cnt_reg == RPT_W'(REPEAT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || mode_press || !(level_vec[1] || level_vec[2])) begin
      rpt_cnt_reg   <= '0;
      rpt_armed_reg <= 1'b0;
    end else if (inc_press || dec_press) begin
      rpt_cnt_reg   <= '0;
      rpt_armed_reg <= (state_reg != RUN);
    end else if (!rpt_active || rpt_fire) begin
      rpt_cnt_reg <= '0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
    end
  end

  assign inc_step = inc_press || (rpt_fire && level_vec[1]);
  assign dec_step = dec_press || (rpt_fire && level_vec[2]);
`else
  logic [31:0] unused_repeat;

  assign unused_repeat = REPEAT_CYCLES;
  assign inc_step      = inc_press;
  assign dec_step      = dec_press;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= RUN;
      load_reg         <= 1'b0;
      edit_hours_reg   <= '0;
      edit_minutes_reg <= '0;
      edit_seconds_reg <= '0;
    end else begin
      load_reg <= 1'b0;
      if (mode_press) begin
        case (state_reg)
          RUN: begin
            edit_hours_reg   <= (cur_hours   > HOURS_MAX)  ? '0 : cur_hours;
            edit_minutes_reg <= (cur_minutes > MINSEC_MAX) ? '0 : cur_minutes;
            edit_seconds_reg <= (cur_seconds > MINSEC_MAX) ? '0 : cur_seconds;
            state_reg        <= SET_HOURS;
          end
          SET_HOURS:   state_reg <= SET_MINUTES;
          SET_MINUTES: state_reg <= SET_SECONDS;
          SET_SECONDS: begin
            load_reg  <= 1'b1;
            state_reg <= RUN;
          end
        endcase
      end else if (inc_step ^ dec_step) begin
        case (state_reg)
          SET_HOURS:   edit_hours_reg   <= hours_step(edit_hours_reg, inc_step);
          SET_MINUTES: edit_minutes_reg <= minsec_step(edit_minutes_reg, inc_step);
          SET_SECONDS: edit_seconds_reg <= minsec_step(edit_seconds_reg, inc_step);
          default:     ;
        endcase
      end
    end
  end

  // Every state change comes from a mode press, so that is where the blink phase restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (mode_press) begin
      blink_cnt_reg <= '0;
      blink_reg     <= (state_reg != SET_SECONDS);
    end else if (state_reg == RUN) begin
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_reg <= '0;
      blink_reg     <= ~blink_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  assign tick_en      = (state_reg == RUN) && !load_reg;
  assign load         = load_reg;
  assign edit_hours   = edit_hours_reg;
  assign edit_minutes = edit_minutes_reg;
  assign edit_seconds = edit_seconds_reg;
  assign set_mode     = state_reg;
  assign blink        = blink_reg;

endmodule

// File: tb/tb_binary_clock_set_ctrl.sv
// Directed bench for binary_clock_set_ctrl: vector table plus bounce, simultaneity, reset and blink sequences.
module tb_binary_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, btn_dec;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes, cur_seconds;
  logic       tick_en, load, blink;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes, edit_seconds;
  logic [1:0] set_mode;

  int total = 0;
  int bad   = 0;

  int load_cnt = 0;
  int load_h = 0, load_m = 0, load_s = 0;
  int load_tick = -1;
  int tick_after_load = -1;
  logic load_prev = 1'b0;

  typedef struct {
    logic [2:0] btns;  // {mode, inc, dec}
    int ch, cm, cs;
    int st, eh, em, es, tk, nl, lh, lm, ls;
  } vec_t;

  vec_t vecs[25];

  binary_clock_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_CYCLES    (5),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_dec      (btn_dec),
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .cur_seconds  (cur_seconds),
    .tick_en      (tick_en),
    .load         (load),
    .edit_hours   (edit_hours),
    .edit_minutes (edit_minutes),
    .edit_seconds (edit_seconds),
    .set_mode     (set_mode),
    .blink        (blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_prev) tick_after_load = int'(tick_en);
    if (load) begin
      load_cnt++;
      load_h = int'(edit_hours);
      load_m = int'(edit_minutes);
      load_s = int'(edit_seconds);
      load_tick = int'(tick_en);
    end
    load_prev = load;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Raw edge to FSM effect is 2 sync + 4 debounce + 1 register = 7 edges.
  task automatic press(input logic [2:0] btns);
    btn_mode = btns[2];
    btn_inc  = btns[1];
    btn_dec  = btns[0];
    repeat (7) tick();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hours = '0; cur_minutes = '0; cur_seconds = '0;

    //                btns    ch  cm  cs  st eh  em  es tk nl lh  lm  ls
    vecs[0]  = '{3'b100, 23, 59, 58, 1, 23, 59, 58, 0, 0, 0, 0, 0};
    vecs[1]  = '{3'b010, 23, 59, 58, 1,  0, 59, 58, 0, 0, 0, 0, 0};
    vecs[2]  = '{3'b100, 23, 59, 58, 2,  0, 59, 58, 0, 0, 0, 0, 0};
    vecs[3]  = '{3'b010, 23, 59, 58, 2,  0,  0, 58, 0, 0, 0, 0, 0};
    vecs[4]  = '{3'b100, 23, 59, 58, 3,  0,  0, 58, 0, 0, 0, 0, 0};
    vecs[5]  = '{3'b001, 23, 59, 58, 3,  0,  0, 57, 0, 0, 0, 0, 0};
    vecs[6]  = '{3'b100, 23, 59, 58, 0,  0,  0, 57, 1, 1, 0, 0, 57};
    vecs[7]  = '{3'b100, 10, 20,  0, 1, 10, 20,  0, 0, 1, 0, 0, 57};
    vecs[8]  = '{3'b001, 10, 20,  0, 1,  9, 20,  0, 0, 1, 0, 0, 57};
    vecs[9]  = '{3'b100, 10, 20,  0, 2,  9, 20,  0, 0, 1, 0, 0, 57};
    vecs[10] = '{3'b001, 10, 20,  0, 2,  9, 19,  0, 0, 1, 0, 0, 57};
    vecs[11] = '{3'b100, 10, 20,  0, 3,  9, 19,  0, 0, 1, 0, 0, 57};
    vecs[12] = '{3'b001, 10, 20,  0, 3,  9, 19, 59, 0, 1, 0, 0, 57};
    vecs[13] = '{3'b010, 10, 20,  0, 3,  9, 19,  0, 0, 1, 0, 0, 57};
    vecs[14] = '{3'b100, 10, 20,  0, 0,  9, 19,  0, 1, 2, 9, 19, 0};
    vecs[15] = '{3'b010, 10, 20,  0, 0,  9, 19,  0, 1, 2, 9, 19, 0};
    vecs[16] = '{3'b001, 10, 20,  0, 0,  9, 19,  0, 1, 2, 9, 19, 0};
    vecs[17] = '{3'b100, 31, 63, 60, 1,  0,  0,  0, 0, 2, 9, 19, 0};
    vecs[18] = '{3'b001, 31, 63, 60, 1, 23,  0,  0, 0, 2, 9, 19, 0};
    vecs[19] = '{3'b011, 31, 63, 60, 1, 23,  0,  0, 0, 2, 9, 19, 0};
    vecs[20] = '{3'b100, 31, 63, 60, 2, 23,  0,  0, 0, 2, 9, 19, 0};
    vecs[21] = '{3'b001, 31, 63, 60, 2, 23, 59,  0, 0, 2, 9, 19, 0};
    vecs[22] = '{3'b100, 31, 63, 60, 3, 23, 59,  0, 0, 2, 9, 19, 0};
    vecs[23] = '{3'b010, 31, 63, 60, 3, 23, 59,  1, 0, 2, 9, 19, 0};
    vecs[24] = '{3'b100, 31, 63, 60, 0, 23, 59,  1, 1, 3, 23, 59, 1};

    // Reset state and idle behaviour.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_tick_en", int'(tick_en), 1);
    chk("reset_set_mode", int'(set_mode), 0);
    chk("reset_load", int'(load), 0);
    chk("reset_blink", int'(blink), 0);
    chk("reset_edit", int'({edit_hours, edit_minutes, edit_seconds}), 0);
    repeat (20) tick();
    chk("idle_loads", load_cnt, 0);
    chk("idle_blink", int'(blink), 0);
    chk("idle_tick_en", int'(tick_en), 1);

    for (int i = 0; i < 25; i++) begin
      cur_hours   = 5'(vecs[i].ch);
      cur_minutes = 6'(vecs[i].cm);
      cur_seconds = 6'(vecs[i].cs);
      press(vecs[i].btns);
      $display("vec %0d btns=%b -> mode=%0d edit=%0d:%0d:%0d tick_en=%0d loads=%0d",
               i, vecs[i].btns, set_mode, edit_hours, edit_minutes, edit_seconds, tick_en, load_cnt);
      chk($sformatf("v%0d_set_mode", i), int'(set_mode), vecs[i].st);
      chk($sformatf("v%0d_hours", i), int'(edit_hours), vecs[i].eh);
      chk($sformatf("v%0d_minutes", i), int'(edit_minutes), vecs[i].em);
      chk($sformatf("v%0d_seconds", i), int'(edit_seconds), vecs[i].es);
      chk($sformatf("v%0d_tick_en", i), int'(tick_en), vecs[i].tk);
      chk($sformatf("v%0d_loads", i), load_cnt, vecs[i].nl);
      if (vecs[i].nl != 0) begin
        chk($sformatf("v%0d_load_val", i), load_h * 10000 + load_m * 100 + load_s,
            vecs[i].lh * 10000 + vecs[i].lm * 100 + vecs[i].ls);
        chk($sformatf("v%0d_tick_in_load", i), load_tick, 0);
        chk($sformatf("v%0d_tick_after_load", i), tick_after_load, 1);
      end
    end

    // Bounce on inc in SET_HOURS: only the final steady edge counts.
    cur_hours = 5'd4; cur_minutes = 6'd0; cur_seconds = 6'd0;
    press(3'b100);
    chk("bounce_entry_hours", int'(edit_hours), 4);
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      repeat (2) tick();
    end
    chk("bounce_no_step", int'(edit_hours), 4);
    btn_inc = 1'b1;
    repeat (6) tick();
    chk("bounce_before_pulse", int'(edit_hours), 4);
    tick();
    chk("bounce_after_pulse", int'(edit_hours), 5);
    $display("bounce: edit_hours=%0d", edit_hours);
    btn_inc = 1'b0;
    repeat (8) tick();
    chk("bounce_single_step", int'(edit_hours), 5);

    // Mode and inc in the same cycle: mode wins.
    press(3'b110);
    $display("mode+inc: mode=%0d edit_hours=%0d", set_mode, edit_hours);
    chk("simul_set_mode", int'(set_mode), 2);
    chk("simul_hours", int'(edit_hours), 5);

    // Reset in SET_MINUTES: back to RUN without a load pulse.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset mid-edit: mode=%0d tick_en=%0d loads=%0d", set_mode, tick_en, load_cnt);
    chk("rst_edit_set_mode", int'(set_mode), 0);
    chk("rst_edit_tick_en", int'(tick_en), 1);
    repeat (5) tick();
    chk("rst_edit_loads", load_cnt, 3);
    chk("rst_edit_load_low", int'(load), 0);

    // Blink: 1 on entry, toggles every 5 cycles, restarts on state change.
    btn_mode = 1'b1;
    repeat (7) tick();
    chk("blink_entry_mode", int'(set_mode), 1);
    chk("blink_entry", int'(blink), 1);
    repeat (4) tick();
    chk("blink_hold", int'(blink), 1);
    tick();
    chk("blink_toggle0", int'(blink), 0);
    repeat (5) tick();
    chk("blink_toggle1", int'(blink), 1);
    btn_mode = 1'b0;
    repeat (8) tick();
    btn_mode = 1'b1;
    repeat (7) tick();
    $display("blink restart: mode=%0d blink=%0d", set_mode, blink);
    chk("blink_restart_mode", int'(set_mode), 2);
    chk("blink_restart", int'(blink), 1);
    repeat (4) tick();
    chk("blink_restart_hold", int'(blink), 1);
    btn_mode = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("blink_run", int'(blink), 0);

`ifdef BINARY_CLOCK_AUTO_REPEAT_EN
    // Held inc for 30 cycles: initial step plus repeats at 8, 16, 24.
    cur_hours = 5'd0;
    press(3'b100);
    btn_inc = 1'b1;
    repeat (30) tick();
    btn_inc = 1'b0;
    repeat (12) tick();
    $display("auto-repeat: edit_hours=%0d", edit_hours);
    chk("repeat_steps", int'(edit_hours), 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
